// File: rtl/bcd_updown_counter_pkg.sv
// Shared encodings for the cascaded up/down counter and its digit cells.
package bcd_updown_counter_pkg;

    localparam int DW = 4;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_e;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

endpackage

// File: rtl/bcd_digit.sv
// One radix-(TOP+1) digit cell: clamped preset load, single-step up/down on carry-in.
module bcd_digit
    import bcd_updown_counter_pkg::*;
#(
    parameter int TOP = 9
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          EN,
    input  logic          CIN,
    input  logic          DIR,
    input  logic          LDEN,
    input  logic          LD,
    input  logic [DW-1:0] LDV,
    output logic [DW-1:0] Q,
    output logic          COUT
);

    localparam logic [DW-1:0] TOPV = DW'(TOP);

    logic [DW-1:0] ld_clamped;

    assign ld_clamped = (LDV > TOPV) ? TOPV : LDV;
    assign COUT       = CIN & ((DIR == DIR_DN) ? (Q == '0) : (Q == TOPV));

    // LDEN permits a count step; the top drops it to hold a saturated value.
    always_ff @(posedge CK) begin
        if (RST) begin
            Q <= '0;
        end else if (EN) begin
            if (LD) begin
                Q <= ld_clamped;
            end else if (CIN && LDEN) begin
                if (DIR == DIR_DN)
                    Q <= (Q == '0) ? TOPV : Q - 4'd1;
                else
                    Q <= (Q == TOPV) ? '0 : Q + 4'd1;
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit cascaded up/down counter with preset load, wrap/saturate limits,
// overflow/underflow pulses and leading-zero blank mask for the LED converter.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int TOP    = 9,
    parameter int LZB    = 1
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 C1K,
    input  logic                 CE,
    input  logic                 DIR,
    input  logic                 MODE,
    input  logic                 LD,
    input  logic [DW*DIGITS-1:0] LDVAL,
    output logic [DW*DIGITS-1:0] VAL,
    output logic [DIGITS-1:0]    BLANK,
    output logic                 OVF,
    output logic                 UNF,
    output logic                 ZERO
);

    logic [DIGITS:0] carry;
    logic            limit;
    logic            step_ok;
    logic            lz_run;

    // A load suppresses the count, so the carry chain never reaches the limit during LD.
    assign carry[0] = CE & ~LD;
    assign limit    = carry[DIGITS];
    assign step_ok  = ~(limit & (MODE == MODE_SAT));

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit #(.TOP(TOP)) u_digit (
            .CK   (CK),
            .RST  (RST),
            .EN   (C1K),
            .CIN  (carry[i]),
            .DIR  (DIR),
            .LDEN (step_ok),
            .LD   (LD),
            .LDV  (LDVAL[DW*i +: DW]),
            .Q    (VAL[DW*i +: DW]),
            .COUT (carry[i+1])
        );
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            OVF <= 1'b0;
            UNF <= 1'b0;
        end else begin
            OVF <= C1K & limit & (DIR == DIR_UP);
            UNF <= C1K & limit & (DIR == DIR_DN);
        end
    end

    assign ZERO = (VAL == '0);

    // Scan from the most significant digit down; digit 0 is never blanked.
    always_comb begin
        BLANK  = '0;
        lz_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run   = lz_run & (VAL[DW*i +: DW] == '0);
            BLANK[i] = (LZB != 0) & lz_run;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Scoreboard bench: a 2-digit BCD instance and a 4-digit hex instance share stimulus.
module tb_bcd_updown_counter;

    logic        CK;
    logic        RST, C1K, CE, DIR, MODE, LD;
    logic [7:0]  LDVAL_A, VAL_A;
    logic [15:0] LDVAL_B, VAL_B;
    logic [1:0]  BLANK_A;
    logic [3:0]  BLANK_B;
    logic        OVF_A, UNF_A, ZERO_A, OVF_B, UNF_B, ZERO_B;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        bit          dut;
        logic [31:0] val;
        logic [31:0] blank;
        logic        ovf;
        logic        unf;
        logic        zero;
    } exp_t;

    exp_t sb[$];

    int mv[2];
    int nd[2]  = '{2, 4};
    int rdx[2] = '{10, 16};

    bcd_updown_counter #(.DIGITS(2), .TOP(9), .LZB(1)) u_dut_a (
        .CK(CK), .RST(RST), .C1K(C1K), .CE(CE), .DIR(DIR), .MODE(MODE), .LD(LD),
        .LDVAL(LDVAL_A), .VAL(VAL_A), .BLANK(BLANK_A), .OVF(OVF_A), .UNF(UNF_A), .ZERO(ZERO_A)
    );

    bcd_updown_counter #(.DIGITS(4), .TOP(15), .LZB(1)) u_dut_b (
        .CK(CK), .RST(RST), .C1K(C1K), .CE(CE), .DIR(DIR), .MODE(MODE), .LD(LD),
        .LDVAL(LDVAL_B), .VAL(VAL_B), .BLANK(BLANK_B), .OVF(OVF_B), .UNF(UNF_B), .ZERO(ZERO_B)
    );

    initial begin
        CK = 1'b0;
        forever #5 CK = ~CK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] encode(input int v, input int n, input int r);
        logic [31:0] x = '0;
        for (int i = 0; i < n; i++) begin
            x[4*i +: 4] = 4'(v % r);
            v = v / r;
        end
        return x;
    endfunction

    function automatic int decode_clamp(input logic [31:0] x, input int n, input int r);
        int v = 0;
        int d;
        for (int i = n - 1; i >= 0; i--) begin
            d = int'(x[4*i +: 4]);
            if (d > r - 1) d = r - 1;
            v = v * r + d;
        end
        return v;
    endfunction

    function automatic logic [31:0] blank_of(input int v, input int n, input int r);
        logic [31:0] b = '0;
        int lead = 1;
        for (int i = 1; i < n; i++) lead = lead * r;
        // Digit i is blank when the value is below r**i; digit 0 never is.
        for (int i = n - 1; i > 0; i--) begin
            b[i] = (v < lead);
            lead = lead / r;
        end
        return b;
    endfunction

    task automatic step(input string tag, input bit rst, input bit c1k, input bit ce,
                        input bit dir, input bit mode, input bit ld, input logic [31:0] ldval);
        exp_t e;
        int   mx;
        bit   o, u;
        RST = rst; C1K = c1k; CE = ce; DIR = dir; MODE = mode; LD = ld;
        LDVAL_A = ldval[7:0];
        LDVAL_B = ldval[15:0];
        for (int d = 0; d < 2; d++) begin
            mx = 1;
            for (int i = 0; i < nd[d]; i++) mx = mx * rdx[d];
            mx = mx - 1;
            o = 1'b0;
            u = 1'b0;
            if (rst) begin
                mv[d] = 0;
            end else if (c1k) begin
                if (ld) begin
                    mv[d] = decode_clamp(ldval, nd[d], rdx[d]);
                end else if (ce && !dir) begin
                    if (mv[d] == mx) begin
                        o = 1'b1;
                        mv[d] = mode ? mx : 0;
                    end else begin
                        mv[d] = mv[d] + 1;
                    end
                end else if (ce && dir) begin
                    if (mv[d] == 0) begin
                        u = 1'b1;
                        mv[d] = mode ? 0 : mx;
                    end else begin
                        mv[d] = mv[d] - 1;
                    end
                end
            end
            e.tag   = $sformatf("%s.%s", tag, d ? "hex4" : "bcd2");
            e.dut   = bit'(d);
            e.val   = encode(mv[d], nd[d], rdx[d]);
            e.blank = blank_of(mv[d], nd[d], rdx[d]);
            e.ovf   = o;
            e.unf   = u;
            e.zero  = (mv[d] == 0);
            sb.push_back(e);
        end
        @(posedge CK);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut) begin
                chk({e.tag, ".val"},   32'(VAL_B),   e.val);
                chk({e.tag, ".blank"}, 32'(BLANK_B), e.blank);
                chk({e.tag, ".ovf"},   32'(OVF_B),   32'(e.ovf));
                chk({e.tag, ".unf"},   32'(UNF_B),   32'(e.unf));
                chk({e.tag, ".zero"},  32'(ZERO_B),  32'(e.zero));
            end else begin
                chk({e.tag, ".val"},   32'(VAL_A),   e.val);
                chk({e.tag, ".blank"}, 32'(BLANK_A), e.blank);
                chk({e.tag, ".ovf"},   32'(OVF_A),   32'(e.ovf));
                chk({e.tag, ".unf"},   32'(UNF_A),   32'(e.unf));
                chk({e.tag, ".zero"},  32'(ZERO_A),  32'(e.zero));
            end
        end
    endtask

    initial begin
        RST = 1'b1; C1K = 1'b0; CE = 1'b0; DIR = 1'b0; MODE = 1'b0; LD = 1'b0;
        LDVAL_A = '0; LDVAL_B = '0;
        mv[0] = 0; mv[1] = 0;
        #2;
        //    tag          rst c1k ce dir mode ld ldval
        step("reset",      1, 0, 0, 0, 0, 0, 32'h0000);
        step("ld09",       0, 1, 0, 0, 0, 1, 32'h0009);
        step("up_carry",   0, 1, 1, 0, 0, 0, 32'h0000);
        for (int i = 0; i < 5; i++)
            step("ce_no_tick", 0, 0, 1, 0, 0, 0, 32'h0000);
        step("ld99",       0, 1, 0, 0, 0, 1, 32'h0099);
        step("ovf_wrap",   0, 1, 1, 0, 0, 0, 32'h0000);
        step("ovf_clear",  0, 1, 0, 0, 0, 0, 32'h0000);
        step("ld99s",      0, 1, 0, 0, 1, 1, 32'h0099);
        step("ovf_sat",    0, 1, 1, 0, 1, 0, 32'h0000);
        step("ovf_clr_s",  0, 0, 0, 0, 1, 0, 32'h0000);
        step("ld00",       0, 1, 0, 1, 0, 1, 32'h0000);
        step("unf_wrap",   0, 1, 1, 1, 0, 0, 32'h0000);
        step("unf_clear",  0, 1, 0, 1, 0, 0, 32'h0000);
        step("ld00s",      0, 1, 0, 1, 1, 1, 32'h0000);
        step("unf_sat",    0, 1, 1, 1, 1, 0, 32'h0000);
        step("unf_clr_s",  0, 1, 0, 1, 1, 0, 32'h0000);
        step("ld_ce_clamp",0, 1, 1, 0, 0, 1, 32'h005F);
        step("ld10",       0, 1, 0, 0, 0, 1, 32'h0100);
        step("dn_borrow",  0, 1, 1, 1, 0, 0, 32'h0000);
        step("ld0ffe",     0, 1, 0, 0, 0, 1, 32'h0FFE);
        step("up_0fff",    0, 1, 1, 0, 0, 0, 32'h0000);
        step("idle",       0, 1, 0, 0, 0, 0, 32'h0000);
        step("rst_on_ce",  1, 1, 1, 0, 0, 0, 32'h0000);
        step("ldffff",     0, 1, 0, 0, 0, 1, 32'hFFFF);
        step("hex_wrap",   0, 1, 1, 0, 0, 0, 32'h0000);
        step("rst_mid_ld", 1, 1, 0, 0, 0, 1, 32'h1234);
        for (int i = 0; i < 60; i++)
            step("rand", ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 5) == 0), $urandom);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
Parametrised multi-digit cascaded up/down counter, the successor to the single-digit key-driven counters in the board-level LSI tops. A debounced key pulse from the key-on detector advances it; it runs off the 1 kHz enable tick and presents per-digit values plus a leading-zero blank mask that feed the 4-digit LED converter directly. Adds width, direction, preset load, and wrap/saturate modes, with overflow and underflow reporting.

Parameters:
DIGITS, 4, number of cascaded 4-bit digits (1..8)
TOP, 9, maximum value of each digit, so the radix is TOP+1 (1..15; 9 gives BCD, 15 gives hex)
LZB, 1, 1 enables leading-zero blanking; 0 forces BLANK to all zeros

Ports:
CK  in  1  system clock; only clock in the block
RST  in  1  synchronous, active-high reset
C1K  in  1  1 kHz enable tick; all state changes are qualified by C1K=1
CE  in  1  count event, one C1K-cycle pulse from KeyOnDetB
DIR  in  1  0 = count up, 1 = count down
MODE  in  1  0 = wrap at limits, 1 = saturate at limits
LD  in  1  preset load request
LDVAL  in  4*DIGITS  preset value; digit i sits at bits [4i+3:4i]
VAL  out  4*DIGITS  current count; digit 0 is least significant
BLANK  out  DIGITS  1 = digit is a leading zero (matches the LEDConv4DC Brank polarity)
OVF  out  1  overflow pulse
UNF  out  1  underflow pulse
ZERO  out  1  1 when every digit is 0

Behaviour:
- Reset: on a CK edge with RST=1, VAL=0, OVF=0, UNF=0. Reset is synchronous, overrides everything, and applies mid-count or mid-load.
- Effective cycle: a CK edge with RST=0 and C1K=1. On all other CK edges the state holds and OVF/UNF go to 0.
- Priority within an effective cycle: LD over CE. If LD=1, the counter loads LDVAL and CE is ignored.
- Load clamping: any LDVAL digit greater than TOP loads as TOP. A load never asserts OVF or UNF.
- Count up (CE=1, DIR=0):
  - Digit 0 increments.
  - A digit at TOP that receives a carry goes to 0 and passes a carry to the next digit.
  - The carry ripples combinationally, so the whole update lands on the same edge.
- Count down (CE=1, DIR=1): the mirror of count up. A digit at 0 that receives a borrow goes to TOP and passes a borrow upward.
- Overflow (all digits at TOP, counting up):
  - MODE=0: VAL wraps to all zeros.
  - MODE=1: VAL holds at all-TOP.
  - Both modes: OVF=1.
- Underflow (all digits at 0, counting down):
  - MODE=0: VAL wraps to all-TOP.
  - MODE=1: VAL holds at 0.
  - Both modes: UNF=1.
- Pulse width: OVF and UNF are registered, rise on the same edge VAL updates, and last exactly one CK cycle.
- Latency: VAL changes on the effective edge itself; there are no pipeline stages.
- ZERO is decoded combinationally from the VAL registers.
- BLANK (combinational from VAL):
  - BLANK[i]=1 when LZB=1, i>0, and digits i down to DIGITS-1 are all 0.
  - BLANK[0] is always 0, so a count of 0 shows a single "0".
- CE held high across several effective cycles counts once per effective cycle; edge detection is the key detector's job.
- Any register values outside 0..TOP are unreachable by construction.

Decomposition:
- Shared package holds DIR_UP/DIR_DN and MODE_WRAP/MODE_SAT encodings, plus the digit width constant DW=4.
- One natural sub-module, bcd_digit. Parameter: TOP. Inputs: CK, RST, EN, CIN, DIR, LDEN, LD, LDV. Outputs: Q, COUT.
- COUT = CIN & (DIR ? Q==0 : Q==TOP).
- The top-level instantiates bcd_digit DIGITS times in a generate loop. It adds limit detection (AND of all carries), the saturate hold, the OVF/UNF registers, and the BLANK/ZERO decode.

Test Plan:
- DIGITS=2, TOP=9, MODE=0. RST=1 for one edge -> VAL=8'h00, BLANK=2'b10, ZERO=1, OVF=UNF=0.
- From 8'h09, one CE up pulse with C1K=1 -> VAL=8'h10, BLANK=2'b00. Then CE=1 with C1K=0 for 5 CK cycles -> VAL stays 8'h10.
- Load 8'h99, then CE up with MODE=0 -> VAL=8'h00 and OVF high for exactly 1 CK. Repeat with MODE=1 -> VAL=8'h99 and OVF high for 1 CK.
- VAL=8'h00, CE down with MODE=0 -> VAL=8'h99 and UNF pulse. With MODE=1 -> VAL=8'h00 and UNF pulse.
- LD=1 and CE=1 together, LDVAL=8'h5F -> VAL=8'h59 (clamped), no count, no OVF.
- DIGITS=4, TOP=15, counting up from 16'h0FFE. Assert RST on the edge after the second CE -> VAL=16'h0000 on that edge, and no OVF.
